// File: rtl/l1_cache_if.sv
// l1_cache_if: bundles the processor-side request/response signals and the
// next-level block interface of the L1 cache.
//   proc_read/proc_write/proc_addr/proc_wdata : processor request
//   proc_stall/proc_rdata                     : cache response
//   mem_read/mem_write/mem_addr/mem_wdata     : block request to next level
//   mem_rdata/mem_ready                       : next-level response
//   cache_reset                               : reset forwarded to next level
// Modports: master = processor + memory side (drives requests and memory
// responses), slave = the cache itself.
interface l1_cache_if;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_rdata;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic         cache_reset;

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata,
           cache_reset
  );

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata,
           cache_reset
  );
endinterface

// File: rtl/l1_cache.sv
// l1_cache: direct-mapped, write-back, write-allocate L1 cache.
// 8 lines of 4 x 32-bit words; word address [29:5] tag, [4:2] index, [1:0] offset.
// Ports:
//   clk        : single clock, all state changes on its rising edge
//   proc_reset : asynchronous active-high reset
//   bus        : l1_cache_if.slave (processor request/response, block
//                interface to the next level, forwarded reset)
// Hits complete combinationally in the same cycle; misses stall through an
// optional WRITEBACK of a dirty victim and an ALLOCATE of the missing block.
module l1_cache (
  input logic       clk,
  input logic       proc_reset,
  l1_cache_if.slave bus
);

  typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t       state;
  logic [7:0]   valid;
  logic [7:0]   dirty;
  logic [24:0]  tag_mem  [8];
  logic [127:0] data_mem [8];
  logic         mem_read_r;
  logic         mem_write_r;

  logic [24:0]  req_tag;
  logic [2:0]   idx;
  logic [1:0]   off;
  logic         req;
  logic         hit;
  logic         write_hit;

  assign req_tag = bus.proc_addr[29:5];
  assign idx     = bus.proc_addr[4:2];
  assign off     = bus.proc_addr[1:0];

  assign req       = bus.proc_read | bus.proc_write;
  assign hit       = req & valid[idx] & (tag_mem[idx] == req_tag);
  // A simultaneous read and write is handled as a write.
  assign write_hit = (state == COMPARE) & hit & bus.proc_write;

  assign bus.proc_stall  = (state != COMPARE) | (req & ~hit);
  assign bus.proc_rdata  = data_mem[idx][{off, 5'b00000} +: 32];
  assign bus.mem_read    = mem_read_r;
  assign bus.mem_write   = mem_write_r;
  // The processor holds its address during a miss, so the victim line is
  // still selected by idx while writing it back.
  assign bus.mem_addr    = (state == WRITEBACK) ? {tag_mem[idx], idx}
                                                : bus.proc_addr[29:2];
  assign bus.mem_wdata   = data_mem[idx];
  assign bus.cache_reset = proc_reset;

  // Control state: FSM, line status bits and registered memory strobes.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state       <= COMPARE;
      valid       <= '0;
      dirty       <= '0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
    end else begin
      case (state)
        COMPARE: begin
          if (write_hit) begin
            dirty[idx] <= 1'b1;
          end else if (req && !hit) begin
            if (valid[idx] && dirty[idx]) begin
              state       <= WRITEBACK;
              mem_write_r <= 1'b1;
            end else begin
              state      <= ALLOCATE;
              mem_read_r <= 1'b1;
            end
          end
        end
        WRITEBACK: begin
          if (bus.mem_ready) begin
            state       <= ALLOCATE;
            mem_write_r <= 1'b0;
            mem_read_r  <= 1'b1;
          end
        end
        ALLOCATE: begin
          if (bus.mem_ready) begin
            state      <= COMPARE;
            mem_read_r <= 1'b0;
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
          end
        end
        default: begin
          state       <= COMPARE;
          mem_read_r  <= 1'b0;
          mem_write_r <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data storage carry no reset. Reset forces the FSM to COMPARE and
  // clears valid, so neither write below can fire while reset is asserted
  // and an aborted fill leaves the line untouched.
  always_ff @(posedge clk) begin
    if (write_hit) begin
      data_mem[idx][{off, 5'b00000} +: 32] <= bus.proc_wdata;
    end else if (state == ALLOCATE && bus.mem_ready) begin
      data_mem[idx] <= bus.mem_rdata;
      tag_mem[idx]  <= req_tag;
    end
  end

endmodule

// File: tb/tb_l1_cache.sv
// tb_l1_cache: directed self-checking bench for l1_cache with a backing
// memory model (word i initially holds i) that answers each block request
// two cycles after it is raised.
module tb_l1_cache;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic proc_reset;
  l1_cache_if bus ();

  l1_cache dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_fill = 0;
  int n_wb   = 0;
  logic [31:0] mem [1024];

  // Backing memory: acts on falling edges so mem_ready/mem_rdata are stable
  // well before the rising edge that consumes them.
  initial begin
    int cnt;
    int base;
    cnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    for (int i = 0; i < 1024; i++) mem[i] = i;
    forever begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (proc_reset) begin
        cnt = 0;
      end else if (bus.mem_read || bus.mem_write) begin
        cnt++;
        if (cnt == LAT) begin
          cnt  = 0;
          base = int'(bus.mem_addr[7:0]) * 4;
          bus.mem_ready = 1'b1;
          if (bus.mem_write) begin
            for (int w = 0; w < 4; w++) mem[base + w] = bus.mem_wdata[32*w +: 32];
            n_wb++;
          end else begin
            for (int w = 0; w < 4; w++) bus.mem_rdata[32*w +: 32] = mem[base + w];
            n_fill++;
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] d);
    bus.proc_read  = rd;
    bus.proc_write = wr;
    bus.proc_addr  = a;
    bus.proc_wdata = d;
  endtask

  // Called just after a rising edge; holds the request until the cache
  // stops stalling, returns the read data and the number of stalled cycles.
  task automatic access(input logic rd, input logic wr, input logic [29:0] a,
                        input logic [31:0] d, output logic [31:0] rdata, output int stalls);
    logic done;
    done   = 1'b0;
    stalls = 0;
    rdata  = '0;
    drive(rd, wr, a, d);
    for (int c = 0; c < 60; c++) begin
      #6;
      if (bus.mem_read && bus.mem_write) check("mem_excl", {bus.mem_read, bus.mem_write}, 2'b10);
      if (!bus.proc_stall) begin
        rdata = bus.proc_rdata;
        done  = 1'b1;
      end
      @(posedge clk); #1;
      if (done) break;
      stalls++;
    end
    if (!done) check("access_done", done, 1'b1);
    drive(1'b0, 1'b0, a, d);
  endtask

  task automatic apply_reset();
    drive(1'b0, 1'b0, '0, '0);
    proc_reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    proc_reset = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int st;
    int f0, w0, bad;

    // Reset state
    proc_reset = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    #1;
    check("rst_cache_reset", bus.cache_reset, 1'b1);
    check("rst_mem_read", bus.mem_read, 1'b0);
    check("rst_mem_write", bus.mem_write, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    proc_reset = 1'b0;

    // Idle after reset
    repeat (3) begin @(posedge clk); #1; end
    #6;
    check("idle_stall", bus.proc_stall, 1'b0);
    check("idle_mem", {bus.mem_read, bus.mem_write}, 2'b00);
    check("idle_cache_reset", bus.cache_reset, 1'b0);
    @(posedge clk); #1;

    // First read misses: one compare cycle, then ALLOCATE for LAT cycles
    drive(1'b1, 1'b0, 30'd0, '0);
    #6;
    check("miss0_stall", bus.proc_stall, 1'b1);
    check("miss0_compare_mem", {bus.mem_read, bus.mem_write}, 2'b00);
    @(posedge clk); #1; #6;
    check("miss0_mem_read", bus.mem_read, 1'b1);
    check("miss0_mem_addr", bus.mem_addr, 28'd0);
    @(posedge clk); #1;
    access(1'b1, 1'b0, 30'd0, '0, rd, st);
    check("miss0_rdata", rd, 32'd0);
    check("miss0_tail_stalls", st, 1);
    for (int a = 1; a < 4; a++) begin
      access(1'b1, 1'b0, 30'(a), '0, rd, st);
      check("hit_rdata", rd, 32'(a));
      check("hit_stalls", st, 0);
    end

    // Idle cycles change nothing: addr 2 still hits
    repeat (4) begin @(posedge clk); #1; end
    #6;
    check("idle2_mem", {bus.mem_read, bus.mem_write, bus.proc_stall}, 3'b000);
    @(posedge clk); #1;
    access(1'b1, 1'b0, 30'd2, '0, rd, st);
    check("idle2_hit_rdata", rd, 32'd2);
    check("idle2_hit_stalls", st, 0);

    // Reset during ALLOCATE (addr 64: index 0, tag 2)
    drive(1'b1, 1'b0, 30'd64, '0);
    @(posedge clk); #1; #6;
    check("abort_mem_read_before", bus.mem_read, 1'b1);
    check("abort_mem_addr", bus.mem_addr, 28'd16);
    #1;
    proc_reset = 1'b1;
    #1;
    check("abort_mem_read", bus.mem_read, 1'b0);
    check("abort_mem_write", bus.mem_write, 1'b0);
    check("abort_cache_reset", bus.cache_reset, 1'b1);
    drive(1'b0, 1'b0, '0, '0);
    @(posedge clk); @(posedge clk); #1;
    proc_reset = 1'b0;
    access(1'b1, 1'b0, 30'd0, '0, rd, st);
    check("post_abort_rdata", rd, 32'd0);
    check("post_abort_stalls", st, LAT + 1);

    // Sequential read of 0..1023 from a clean cache
    apply_reset();
    f0 = n_fill; w0 = n_wb; bad = 0;
    for (int a = 0; a < 1024; a++) begin
      access(1'b1, 1'b0, 30'(a), '0, rd, st);
      if (rd !== 32'(a)) begin
        bad++;
        check("seq_rdata", rd, 32'(a));
      end
    end
    check("seq_bad_count", bad, 0);
    check("seq_fills", n_fill - f0, 256);
    check("seq_writebacks", n_wb - w0, 0);

    // Dirty eviction: write 16 to addr 5, then read addr 37 (same index 1)
    access(1'b0, 1'b1, 30'd5, 32'd16, rd, st);
    check("wr5_stalls", st, LAT + 1);
    drive(1'b1, 1'b0, 30'd37, '0);
    #6;
    check("rd37_compare_stall", bus.proc_stall, 1'b1);
    check("rd37_compare_mem", {bus.mem_read, bus.mem_write}, 2'b00);
    @(posedge clk); #1; #6;
    check("wb_mem", {bus.mem_read, bus.mem_write}, 2'b01);
    check("wb_mem_addr", bus.mem_addr, 28'd1);
    check("wb_word1", bus.mem_wdata[63:32], 32'd16);
    check("wb_block", bus.mem_wdata, {32'd7, 32'd6, 32'd16, 32'd4});
    @(posedge clk); #1;
    @(posedge clk); #1; #6;
    check("alloc37_mem", {bus.mem_read, bus.mem_write}, 2'b10);
    check("alloc37_mem_addr", bus.mem_addr, 28'd9);
    @(posedge clk); #1;
    access(1'b1, 1'b0, 30'd37, '0, rd, st);
    check("rd37_rdata", rd, 32'd37);
    check("rd37_tail_stalls", st, 1);
    check("wb_mem5", mem[5], 32'd16);

    // Write k*3+1 everywhere, then read it all back
    apply_reset();
    f0 = n_fill; w0 = n_wb;
    for (int a = 0; a < 1024; a++) begin
      access(1'b0, 1'b1, 30'(a), 32'(a * 3 + 1), rd, st);
    end
    check("wpass_fills", n_fill - f0, 256);
    check("wpass_writebacks", n_wb - w0, 248);
    f0 = n_fill; w0 = n_wb; bad = 0;
    for (int a = 0; a < 1024; a++) begin
      access(1'b1, 1'b0, 30'(a), '0, rd, st);
      if (rd !== 32'(a * 3 + 1)) begin
        bad++;
        check("rpass_rdata", rd, 32'(a * 3 + 1));
      end
    end
    check("rpass_bad_count", bad, 0);
    check("rpass_fills", n_fill - f0, 256);
    check("rpass_writebacks", n_wb - w0, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l1_cache.md
L1_CACHE -- requirements
Module: l1_cache

Interface
REQ-001 Parameters: none; 8 lines, 4 x 32-bit words per line, 128-bit blocks, fixed.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 proc_reset  input  1  reset, asynchronous, active-high.
REQ-004 proc_read  input  1  processor read request.
REQ-005 proc_write  input  1  processor write request.
REQ-006 proc_addr  input  30  word address: [29:5] tag, [4:2] index, [1:0] word offset.
REQ-007 proc_wdata  input  32  processor write data.
REQ-008 proc_stall  output  1  high while the current request cannot complete this cycle.
REQ-009 proc_rdata  output  32  read data; valid when proc_read=1 and proc_stall=0.
REQ-010 mem_read  output  1  block read request to the next level.
REQ-011 mem_write  output  1  block write-back request to the next level.
REQ-012 mem_addr  output  28  block address (word address [29:2]).
REQ-013 mem_rdata  input  128  block from the next level; word n at bits [32n+31:32n].
REQ-014 mem_wdata  output  128  evicted block, same word packing.
REQ-015 mem_ready  input  1  next level has completed the pending request; mem_rdata valid this cycle for reads.
REQ-016 cache_reset  output  1  reset forwarded to the next level; equals proc_reset combinationally.

Function
REQ-017 Direct-mapped, write-back, write-allocate; per line: valid, dirty, 25-bit tag, 128-bit data.
REQ-018 Hit = (proc_read|proc_write) & valid[index] & tag match; evaluated combinationally.
REQ-019 Read hit: proc_stall=0 same cycle, proc_rdata = selected word combinationally; no memory traffic.
REQ-020 Write hit: proc_stall=0 same cycle; word written and dirty set at the rising edge.
REQ-021 proc_read and proc_write both high: treated as a write.
REQ-022 Neither request high: proc_stall=0, no memory traffic, no state change.
REQ-023 FSM states: COMPARE (idle/hit check), WRITEBACK, ALLOCATE.
REQ-024 COMPARE, miss, victim dirty -> WRITEBACK; miss, victim clean or invalid -> ALLOCATE; proc_stall=1 on any miss.
REQ-025 WRITEBACK: mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim block; held stable until mem_ready=1, then -> ALLOCATE.
REQ-026 ALLOCATE: mem_read=1, mem_addr=proc_addr[29:2]; held until mem_ready=1; at that edge line gets mem_rdata, tag, valid=1, dirty=0; -> COMPARE.
REQ-027 After allocation the request re-evaluates as a hit in COMPARE (write hit then merges proc_wdata); miss penalty = memory latency + 1 cycle (+ write-back latency if dirty).
REQ-028 proc_stall=1 throughout WRITEBACK and ALLOCATE.
REQ-029 mem_read and mem_write never both high; both low in COMPARE.
REQ-030 Processor holds request, address and data stable while proc_stall=1; inputs change shortly after a rising edge and the response is sampled just before the next edge.
REQ-031 Timing target: cycle 11.6 ns, hit path combinational within one cycle.

Reset
REQ-032 proc_reset=1 asynchronously: all valid=0, dirty=0, FSM -> COMPARE, mem_read=0, mem_write=0; data array contents need not be cleared.
REQ-033 Reset asserted mid-miss aborts the transaction; no line is updated and the next level is reset via cache_reset.
REQ-034 proc_stall and proc_rdata are don't-care during reset; cache_reset=1 throughout.

Verification
REQ-035 Backing memory word i = i: after reset, read addr 0 -> proc_stall=1, mem_read=1 with mem_addr=0 until mem_ready, then proc_rdata=0 with proc_stall=0; addrs 1-3 hit with no stall, data 1,2,3.
REQ-036 Sequential read of word addrs 0..1023 -> every proc_rdata equals its address; exactly one miss per 4-word block.
REQ-037 Write k*3+1 to addrs 0..1023, then read 0..1023 -> every proc_rdata equals k*3+1; dirty evictions occur during both passes.
REQ-038 Write 16 to addr 5, then read addr 37 (same index 1) -> mem_write with mem_addr=1 and mem_wdata word1=16, then mem_read with mem_addr=9, proc_rdata=37.
REQ-039 Assert proc_reset during an ALLOCATE -> mem_read drops immediately, cache_reset=1; after release read addr 0 misses again.
REQ-040 Idle cycles (no request) -> proc_stall=0, mem_read=mem_write=0, no state change.
